// File: rtl/uart_tx_sched.sv
// Buffered UART transmit scheduler: CPU byte stores are queued in a FIFO and
// handed to the serializer one at a time, with a polled status word.
//
// state      | meaning
// S_IDLE     | waiting for a queued byte and a quiet serializer
// S_LAUNCH   | one-cycle uart_write_en pulse, byte already latched
// S_WAIT_RISE| waiting (bounded) for uart_busy to acknowledge the launch
// S_WAIT_FALL| serializer busy, waiting for it to finish
module uart_tx_sched #(
   parameter int DEPTH        = 16,
   parameter int AW           = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        wr_en_i,
   input  logic [7:0]  wr_data_i,
   input  logic        clr_overflow_i,
   input  logic        uart_busy_i,
   output logic        uart_write_en_o,
   output logic [7:0]  uart_data_o,
   output logic [31:0] status_word_o
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_RISE, S_WAIT_FALL} state_t;

   state_t          state_q;
   logic [TW-1:0]   tmr_q;
   logic            write_en_q;
   logic [7:0]      data_q;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [AW:0]     count_q, count_d;
   logic            ovf_q;
   logic            full, empty, push, pop, tx_idle;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push    = wr_en_i && !full;
   // Pop decision uses the registered count, so a byte pushed this cycle waits one cycle.
   assign pop     = (state_q == S_IDLE) && !empty && !uart_busy_i;
   assign tx_idle = empty && (state_q == S_IDLE) && !uart_busy_i;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_d;
         if (wr_en_i && full)  ovf_q <= 1'b1;
         else if (clr_overflow_i) ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         tmr_q      <= '0;
         write_en_q <= 1'b0;
         data_q     <= 8'h00;
      end else begin
         write_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  data_q     <= mem_q[rptr_q];
                  write_en_q <= 1'b1;
                  state_q    <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               tmr_q   <= TW'(BUSY_TIMEOUT);
               state_q <= S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
               if (uart_busy_i) begin
                  state_q <= S_WAIT_FALL;
               end else if (tmr_q <= TW'(1)) begin
                  tmr_q   <= '0;
                  state_q <= S_IDLE;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            S_WAIT_FALL: begin
               if (!uart_busy_i) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign uart_write_en_o = write_en_q;
   assign uart_data_o     = data_q;

   always_comb begin
      status_word_o          = '0;
      status_word_o[0]       = !full;
      status_word_o[1]       = empty;
      status_word_o[2]       = tx_idle;
      status_word_o[3]       = ovf_q;
      status_word_o[8 +: AW+1] = count_q;
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: queued bytes are expected at each
// launch pulse, with a small model of the serializer's busy line.
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wdata = 8'h00;
   logic        clr = 1'b0;
   logic        busy = 1'b0;
   logic        wen;
   logic [7:0]  udata;
   logic [31:0] sw;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] sb[$];

   int cyc = 0;
   int launches = 0;
   int last_launch = 0;
   int launch_gap = 0;
   int push_cyc = 0;
   // busy mode: 0 = serializer model, 1 = forced high, 2 = forced low
   int mode = 2;
   int busy_cnt = 0;
   bit launch_prev = 1'b0;

   uart_tx_sched #(.DEPTH(16), .AW(4), .BUSY_TIMEOUT(4)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .wr_en_i        (wr_en),
      .wr_data_i      (wdata),
      .clr_overflow_i (clr),
      .uart_busy_i    (busy),
      .uart_write_en_o(wen),
      .uart_data_o    (udata),
      .status_word_o  (sw)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [7:0] e;
      if (wen) begin
         launch_gap  = cyc - last_launch;
         last_launch = cyc;
         launches++;
         if (sb.size() == 0) chk("launch_expected", 32'(sb.size()), 32'd1);
         else begin
            e = sb.pop_front();
            chk("tx_data", {24'h0, udata}, {24'h0, e});
         end
      end
      if (mode == 1) busy = 1'b1;
      else if (mode == 2) begin busy = 1'b0; busy_cnt = 0; end
      else begin
         if (busy_cnt > 0) busy_cnt--;
         if (launch_prev) busy_cnt = 20;
         busy = (busy_cnt > 0);
      end
      launch_prev = wen;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b, input bit expect_tx);
      wr_en = 1'b1;
      wdata = b;
      push_cyc = cyc;
      if (expect_tx) sb.push_back(b);
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (!(sb.size() == 0 && sw[2]) && n < budget) begin
         step();
         n++;
      end
      chk(tag, {31'h0, sw[2]}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int w;
      repeat (5) @(negedge clk);
      #1;
      chk("rst_status_held", sw, 32'h7);
      rst_n = 1'b1;
      step();
      chk("rst_status", sw, 32'h7);
      chk("rst_data", {24'h0, udata}, 32'h0);
      chk("rst_wen", {31'h0, wen}, 32'h0);
      repeat (5) step();
      chk("rst_no_launch", 32'(launches), 32'd0);

      // single byte
      mode = 0;
      step();
      base = launches;
      push(8'h41, 1'b1);
      wait_idle("single_tx_idle", 100);
      chk("single_latency", 32'(last_launch - push_cyc), 32'd2);
      chk("single_launches", 32'(launches - base), 32'd1);

      // burst with wrap, software polls can_accept
      base = launches;
      for (int i = 0; i < 20; i++) begin
         w = 0;
         while (!sw[0] && w < 500) begin step(); w++; end
         push(8'(i), 1'b1);
      end
      wait_idle("burst_drain", 1500);
      chk("burst_launches", 32'(launches - base), 32'd20);
      chk("burst_status", sw, 32'h7);

      // overflow with serializer held busy
      mode = 1;
      step();
      base = launches;
      for (int i = 0; i < 17; i++) push(8'h80 + 8'(i), i < 16);
      chk("ovf_status", sw, 32'h0000_1008);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("ovf_cleared", sw, 32'h0000_1000);
      wr_en = 1'b1; wdata = 8'hAA; clr = 1'b1;
      step();
      wr_en = 1'b0; clr = 1'b0;
      chk("ovf_set_wins", {31'h0, sw[3]}, 32'd1);
      chk("ovf_count_kept", 32'(sw[12:8]), 32'd16);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("ovf_clear2", {31'h0, sw[3]}, 32'd0);
      mode = 0;
      wait_idle("ovf_drain", 1500);
      chk("ovf_launches", 32'(launches - base), 32'd16);

      // busy never rises: timeout path
      mode = 2;
      step();
      base = launches;
      push(8'h55, 1'b1);
      push(8'h66, 1'b1);
      wait_idle("timeout_drain", 100);
      chk("timeout_launches", 32'(launches - base), 32'd2);
      chk("timeout_gap", 32'(launch_gap), 32'd6);

      // async reset while in WAIT_FALL with three bytes queued
      mode = 0;
      step();
      base = launches;
      push(8'h11, 1'b1);
      push(8'h22, 1'b1);
      push(8'h33, 1'b1);
      push(8'h44, 1'b1);
      w = 0;
      while (launches == base && w < 50) begin step(); w++; end
      chk("midrst_first_launch", 32'(launches - base), 32'd1);
      repeat (4) step();
      chk("midrst_count_before", 32'(sw[12:8]), 32'd3);
      rst_n = 1'b0;
      mode = 2;
      busy_cnt = 0;
      busy = 1'b0;
      #1;
      chk("midrst_status", sw, 32'h7);
      chk("midrst_data", {24'h0, udata}, 32'h0);
      sb.delete();
      base = launches;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (30) step();
      chk("midrst_no_launch", 32'(launches - base), 32'd0);
      chk("midrst_status_after", sw, 32'h7);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
